// File: rtl/pipelined_barrel_shifter.sv
// Multi-mode barrel shifter, one register slice per LEVELS_PER_STAGE levels; latency NSTAGE cycles.
// Stalls the whole pipe while out_valid && !out_ready; out_carry exists only with PIPELINED_BARREL_SHIFTER_CARRY_EN.
module pipelined_barrel_shifter #(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 1,
  parameter int TAG_W            = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [2:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
  ,
  output logic                     out_carry
`endif
);

  localparam int NLEV   = $clog2(WIDTH);
  localparam int NSTAGE = (NLEV + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two in 8..64");
  end
  if (LEVELS_PER_STAGE < 1 || LEVELS_PER_STAGE > NLEV) begin : g_bad_lps
    $error("pipelined_barrel_shifter: LEVELS_PER_STAGE must be in 1..log2(WIDTH)");
  end

  typedef struct packed {
    logic             vld;
    logic [2:0]       op;
    logic             sgn;
    logic [NLEV-1:0]  amt;
    logic [TAG_W-1:0] tag;
    logic             carry;
    logic [WIDTH-1:0] dat;
  } stage_t;

  stage_t stage_d [NSTAGE];
  stage_t stage_q [NSTAGE];
  logic   zero_d;
  logic   zero_q;
  logic   advance;

  // Applies the levels owned by stage s, largest shift first; returns {carry, data}.
  // The carry of the smallest applied level is the overall last bit shifted out.
  function automatic logic [WIDTH:0] shift_levels(input stage_t st, input int s);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] t;
    logic [NLEV-1:0]  a;
    logic             c;
    int               k;
    int               sh;
    d = st.dat;
    c = st.carry;
    for (int j = 0; j < LEVELS_PER_STAGE; j++) begin
      k  = NLEV - 1 - (s * LEVELS_PER_STAGE + j);
      a  = '0;
      sh = 0;
      if (k >= 0) begin
        a  = st.amt >> k;
        sh = 1 << k;
      end
      if (k >= 0 && a[0]) begin
        case (st.op)
          OP_SLL: begin t = d >> (WIDTH - sh); c = t[0]; d = d << sh; end
          OP_SRL: begin t = d >> (sh - 1);     c = t[0]; d = d >> sh; end
          OP_SRA: begin
            t = d >> (sh - 1);
            c = t[0];
            d = (d >> sh) | (st.sgn ? ~({WIDTH{1'b1}} >> sh) : '0);
          end
          OP_ROL: begin t = d >> (WIDTH - sh); c = t[0]; d = (d << sh) | (d >> (WIDTH - sh)); end
          OP_ROR: begin t = d >> (sh - 1);     c = t[0]; d = (d >> sh) | (d << (WIDTH - sh)); end
          default: ;
        endcase
      end
    end
    return {c, d};
  endfunction

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    stage_t         src;
    logic [WIDTH:0] res;
    if (s == 0) begin : g_first
      assign src = '{vld: in_valid, op: in_op, sgn: in_data[WIDTH-1], amt: in_amt,
                     tag: in_tag, carry: 1'b0, dat: in_data};
    end else begin : g_next
      assign src = stage_q[s-1];
    end
    assign res        = shift_levels(src, s);
    assign stage_d[s] = '{vld: src.vld, op: src.op, sgn: src.sgn, amt: src.amt,
                          tag: src.tag, carry: res[WIDTH], dat: res[WIDTH-1:0]};
  end

  assign zero_d  = (stage_d[NSTAGE-1].dat == '0);
  assign advance = !stage_q[NSTAGE-1].vld || out_ready;

  // Global stall: every slice holds together, bubbles are not collapsed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NSTAGE; s++) stage_q[s] <= '0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int s = 0; s < NSTAGE; s++) stage_q[s] <= stage_d[s];
      zero_q <= zero_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = stage_q[NSTAGE-1].vld;
  assign out_data  = stage_q[NSTAGE-1].dat;
  assign out_tag   = stage_q[NSTAGE-1].tag;
  assign out_zero  = zero_q;
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
  assign out_carry = stage_q[NSTAGE-1].carry;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (32-bit/LPS=1 plus an 8-bit/LPS=3 instance).
module tb_pipelined_barrel_shifter;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        zero;
    logic        carry;
    bit          lat;
    int          iss;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          amt;
    logic [2:0]  op;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_carry;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amt, in_tag, out_tag;
  logic [2:0]  in_op;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, out_zero8, out_carry8;
  logic [7:0]  in_data8, out_data8;
  logic [2:0]  in_amt8, in_op8;
  logic [4:0]  in_tag8, out_tag8;

  exp_t sb[$];
  exp_t me;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_in = 0;
  int   n_out = 0;

  pipelined_barrel_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(1), .TAG_W(5)) u_dut (
    .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_zero(out_zero)
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
    , .out_carry(out_carry)
`endif
  );

  pipelined_barrel_shifter #(.WIDTH(8), .LEVELS_PER_STAGE(3), .TAG_W(5)) u_dut8 (
    .clock(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_amt(in_amt8), .in_op(in_op8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_tag(out_tag8), .out_zero(out_zero8)
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
    , .out_carry(out_carry8)
`endif
  );

`ifndef PIPELINED_BARREL_SHIFTER_CARRY_EN
  assign out_carry  = 1'b0;
  assign out_carry8 = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] d, input int amt, input logic [2:0] op,
                                 input logic [4:0] tag);
    exp_t        e;
    logic [31:0] t;
    case (op)
      3'd0:    e.data = d << amt;
      3'd1:    e.data = d >> amt;
      3'd2:    e.data = $signed(d) >>> amt;
      3'd3:    e.data = (d << amt) | (d >> (32 - amt));
      3'd4:    e.data = (d >> amt) | (d << (32 - amt));
      default: e.data = d;
    endcase
    e.carry = 1'b0;
    if (amt != 0 && (op == 3'd0 || op == 3'd3)) begin
      t = d >> (32 - amt);
      e.carry = t[0];
    end
    if (amt != 0 && (op == 3'd1 || op == 3'd2 || op == 3'd4)) begin
      t = d >> (amt - 1);
      e.carry = t[0];
    end
    e.tag  = tag;
    e.zero = (e.data == 32'd0);
    e.lat  = 1'b0;
    e.iss  = 0;
    return e;
  endfunction

  // Expected results retire in order on every output transfer.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      check("out_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        me = sb.pop_front();
        check("out_data", out_data, me.data);
        check("out_tag", out_tag, me.tag);
        check("out_zero", out_zero, me.zero);
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
        check("out_carry", out_carry, me.carry);
`endif
        if (me.lat) check("latency", cyc - me.iss, 5);
        n_out++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the op is accepted.
  task automatic send(input logic [31:0] d, input int amt, input logic [2:0] op,
                      input logic [4:0] tag, input bit lat, input logic [31:0] expd);
    exp_t e;
    int   n;
    in_data = d; in_amt = amt[4:0]; in_op = op; in_tag = tag; in_valid = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("send_timeout", n < 100, 1);
    e = model(d, amt, op, tag);
    e.data = expd;
    e.zero = (expd == 32'd0);
    e.lat = lat;
    e.iss = cyc;
    sb.push_back(e);
    n_in++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  vec_t dir [14];
  exp_t re;

  initial begin
    int nb;
    logic [31:0] rd;
    int ra;
    logic [2:0] rop;

    dir = '{
      '{32'h0000_0001, 31, 3'd0, 5'd7,  32'h8000_0000},
      '{32'h8000_00F0, 4,  3'd2, 5'd1,  32'hF800_000F},
      '{32'h8000_00F0, 4,  3'd1, 5'd2,  32'h0800_000F},
      '{32'h8000_00F0, 31, 3'd2, 5'd3,  32'hFFFF_FFFF},
      '{32'h1234_5678, 8,  3'd3, 5'd4,  32'h3456_7812},
      '{32'h1234_5678, 4,  3'd4, 5'd5,  32'h8123_4567},
      '{32'h0000_0001, 1,  3'd1, 5'd6,  32'h0000_0000},
      '{32'hDEAD_BEEF, 0,  3'd0, 5'd8,  32'hDEAD_BEEF},
      '{32'hDEAD_BEEF, 0,  3'd2, 5'd9,  32'hDEAD_BEEF},
      '{32'hDEAD_BEEF, 0,  3'd4, 5'd10, 32'hDEAD_BEEF},
      '{32'hCAFE_F00D, 13, 3'd5, 5'd11, 32'hCAFE_F00D},
      '{32'hCAFE_F00D, 1,  3'd7, 5'd12, 32'hCAFE_F00D},
      '{32'h8000_0001, 1,  3'd3, 5'd13, 32'h0000_0003},
      '{32'h8000_0001, 1,  3'd4, 5'd14, 32'hC000_0000}
    };

    reset_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; in_data8 = '0; in_amt8 = '0; in_op8 = '0; in_tag8 = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_carry", out_carry, 0);
    check("rst_out_valid8", out_valid8, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Directed ops, one at a time so latency is exact.
    foreach (dir[i]) begin
      send(dir[i].data, dir[i].amt, dir[i].op, dir[i].tag, 1'b1, dir[i].exp);
      drain();
    end

    // Eight back-to-back ops with out_ready low for cycles 6..9.
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      out_ready = !(i >= 6 && i <= 9);
      #1;
      check("bp_in_ready", in_ready, (i >= 6 && i <= 9) ? 0 : 1);
      if (i >= 6 && i <= 9) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", out_data, sb[0].data);
        check("bp_hold_tag", out_tag, sb[0].tag);
      end
      if (in_ready && nb < 8) begin
        rd = 32'h1111_1111 * (nb + 1);
        ra = nb * 3 + 1;
        rop = 3'(nb % 5);
        re = model(rd, ra, rop, 5'(16 + nb));
        in_data = rd; in_amt = ra[4:0]; in_op = rop; in_tag = 5'(16 + nb); in_valid = 1'b1;
        sb.push_back(re);
        n_in++;
        nb++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_all_issued", nb, 8);
    drain();
    check("bp_count", n_out, n_in);

    // Random traffic with random backpressure.
    nb = 0;
    for (int i = 0; i < 200 && nb < 40; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready && $urandom_range(0, 3) != 0) begin
        rd = $urandom; ra = $urandom_range(0, 31); rop = 3'($urandom_range(0, 7));
        re = model(rd, ra, rop, 5'(nb));
        in_data = rd; in_amt = ra[4:0]; in_op = rop; in_tag = 5'(nb); in_valid = 1'b1;
        sb.push_back(re);
        n_in++;
        nb++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    check("rand_count", n_out, n_in);

    // Reset mid-flight with a stalled result at the output.
    out_ready = 1'b0;
    send(32'h0000_00FF, 4, 3'd0, 5'd21, 1'b0, 32'h0000_0FF0);
    send(32'h0000_00FF, 2, 3'd0, 5'd22, 1'b0, 32'h0000_03FC);
    send(32'h0000_00FF, 1, 3'd0, 5'd23, 1'b0, 32'h0000_01FE);
    nb = 0;
    while (!out_valid && nb < 20) begin
      @(posedge clk); #1;
      nb++;
    end
    check("mid_out_valid_seen", out_valid, 1);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_tag", out_tag, 0);
    check("mid_rst_out_zero", out_zero, 0);
    check("mid_rst_in_ready", in_ready, 1);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_quiet", out_valid, 0);
    end
    @(posedge clk); #1;
    send(32'hF0F0_0000, 4, 3'd1, 5'd9, 1'b1, 32'h0F0F_0000);
    drain();

    // WIDTH=8, LPS=3: single stage, latency 1.
    in_data8 = 8'hA5; in_amt8 = 3'd3; in_op8 = 3'd4; in_tag8 = 5'd3; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_amt8 = 3'd5; in_op8 = 3'd7; in_tag8 = 5'd4;
    @(negedge clk);
    check("w8_ror_valid", out_valid8, 1);
    check("w8_ror_data", out_data8, 8'hB4);
    check("w8_ror_tag", out_tag8, 3);
    check("w8_ror_zero", out_zero8, 0);
`ifdef PIPELINED_BARREL_SHIFTER_CARRY_EN
    check("w8_ror_carry", out_carry8, 1);
`endif
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    check("w8_pass_valid", out_valid8, 1);
    check("w8_pass_data", out_data8, 8'hA5);
    check("w8_pass_tag", out_tag8, 4);
    @(negedge clk);
    check("w8_idle_valid", out_valid8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
